// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, bypass/IDCODE instruction code helpers and default IDCODE value
package jtag_pkg;
  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;
  localparam logic [31:0] IDCODE_DEFAULT = 32'h1234_5001;
  function automatic int bypass_code(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic int idcode_code(input int w);
    return (1 << w) - 2;
  endfunction
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state TAP controller on tms (clk, async active-low reset) with capture/shift/update strobes and tlr (in or entering TEST_LOGIC_RESET)
module jtag_tap_fsm import jtag_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       tms,
  output tap_state_t state,
  output logic       cap_ir,
  output logic       sh_ir,
  output logic       upd_ir,
  output logic       cap_dr,
  output logic       sh_dr,
  output logic       upd_dr,
  output logic       tlr
);
  tap_state_t nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= TLR;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      TLR:      nxt = tms ? TLR    : RTI;
      RTI:      nxt = tms ? SEL_DR : RTI;
      SEL_DR:   nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:   nxt = tms ? EX1_DR : SH_DR;
      SH_DR:    nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:   nxt = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: nxt = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:   nxt = tms ? SEL_DR : RTI;
      SEL_IR:   nxt = tms ? TLR    : CAP_IR;
      CAP_IR:   nxt = tms ? EX1_IR : SH_IR;
      SH_IR:    nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:   nxt = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: nxt = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:   nxt = tms ? SEL_DR : RTI;
      default:  nxt = TLR;
    endcase
  end
  assign cap_ir = state == CAP_IR;
  assign sh_ir  = state == SH_IR;
  assign upd_ir = state == UPD_IR;
  assign cap_dr = state == CAP_DR;
  assign sh_dr  = state == SH_DR;
  assign upd_dr = state == UPD_DR;
  assign tlr    = state == TLR || nxt == TLR;
endmodule

// File: rtl/jtag_tap_scan_bank.sv
// jtag_tap_scan_bank: TAP + IR/shadow + NUM_DR shadowed DRs + bypass; ports clk reset(async low) tms tdi -> tdo tdo_en, ir_status -> instruction, dr_capture -> dr_q dr_update, tap_state; JTAG_IDCODE_EN adds IDCODE chain
module jtag_tap_scan_bank import jtag_pkg::*; #(
  parameter int IR_WIDTH = 3,
  parameter int NUM_DR = 2,
  parameter int DR_WIDTH = 8,
  parameter logic [DR_WIDTH-1:0] DR_RESET = {DR_WIDTH{1'b1}}
`ifdef JTAG_IDCODE_EN
  , parameter logic [31:0] IDCODE_VALUE = IDCODE_DEFAULT
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tms,
  input  logic                       tdi,
  output logic                       tdo,
  output logic                       tdo_en,
  input  logic [IR_WIDTH-1:0]        ir_status,
  output logic [IR_WIDTH-1:0]        instruction,
  input  logic [NUM_DR*DR_WIDTH-1:0] dr_capture,
  output logic [NUM_DR*DR_WIDTH-1:0] dr_q,
  output logic [NUM_DR-1:0]          dr_update,
  output logic [3:0]                 tap_state
);
  localparam int SW = $clog2(NUM_DR + 2);
  localparam logic [SW-1:0] S_BYP = SW'(NUM_DR);
`ifdef JTAG_IDCODE_EN
  localparam logic [SW-1:0] S_IDC = SW'(NUM_DR + 1);
  localparam logic [IR_WIDTH-1:0] RST_INSTR = IR_WIDTH'(idcode_code(IR_WIDTH));
`else
  localparam logic [IR_WIDTH-1:0] RST_INSTR = IR_WIDTH'(bypass_code(IR_WIDTH));
`endif
  tap_state_t state;
  logic cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, tlr;
  logic [IR_WIDTH-1:0] ir_chain;
  logic [SW-1:0] sel, sel_q;
  logic [NUM_DR-1:0] dr_msb;
  logic byp, tdo_dr;
  jtag_tap_fsm u_fsm (
    .clk(clk), .reset(reset), .tms(tms), .state(state),
    .cap_ir(cap_ir), .sh_ir(sh_ir), .upd_ir(upd_ir),
    .cap_dr(cap_dr), .sh_dr(sh_dr), .upd_dr(upd_dr), .tlr(tlr)
  );
  assign tap_state = state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ir_chain <= '1;
      instruction <= RST_INSTR;
    end else begin
      ir_chain <= cap_ir ? ir_status : sh_ir ? {ir_chain[IR_WIDTH-2:0], tdi} : ir_chain;
      instruction <= tlr ? RST_INSTR : upd_ir ? ir_chain : instruction;
    end
  always_comb begin
    sel = (int'(instruction) < NUM_DR) ? SW'(instruction) : S_BYP;
`ifdef JTAG_IDCODE_EN
    if (int'(instruction) == idcode_code(IR_WIDTH)) sel = S_IDC;
`endif
  end
  // the selection is frozen at CAPTURE_DR so shift/update act on the chain that was captured
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sel_q <= S_BYP;
      byp <= 1'b0;
    end else begin
      sel_q <= cap_dr ? sel : sel_q;
      byp <= (cap_dr && sel == S_BYP) ? 1'b0 : (sh_dr && sel_q == S_BYP) ? tdi : byp;
    end
  for (genvar i = 0; i < NUM_DR; i++) begin : g_dr
    localparam logic [SW-1:0] ID = SW'(i);
    logic [DR_WIDTH-1:0] ch;
    assign dr_msb[i] = ch[DR_WIDTH-1];
    assign dr_update[i] = upd_dr && sel_q == ID;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        ch <= '0;
        dr_q[i*DR_WIDTH +: DR_WIDTH] <= DR_RESET;
      end else begin
        if (cap_dr && sel == ID) ch <= dr_capture[i*DR_WIDTH +: DR_WIDTH];
        else if (sh_dr && sel_q == ID) ch <= {ch[DR_WIDTH-2:0], tdi};
        if (dr_update[i]) dr_q[i*DR_WIDTH +: DR_WIDTH] <= ch;
      end
  end
`ifdef JTAG_IDCODE_EN
  logic [31:0] idc;
  always_ff @(posedge clk or negedge reset)
    if (!reset) idc <= '0;
    else idc <= (cap_dr && sel == S_IDC) ? IDCODE_VALUE : (sh_dr && sel_q == S_IDC) ? {idc[30:0], tdi} : idc;
`endif
  always_comb begin
    tdo_dr = byp;
    for (int k = 0; k < NUM_DR; k++) if (sel_q == SW'(k)) tdo_dr = dr_msb[k];
`ifdef JTAG_IDCODE_EN
    if (sel_q == S_IDC) tdo_dr = idc[31];
`endif
  end
  assign tdo = sh_ir ? ir_chain[IR_WIDTH-1] : sh_dr ? tdo_dr : 1'b0;
  assign tdo_en = sh_ir | sh_dr;
endmodule

// File: tb/tb_jtag_tap_scan_bank.sv
// tb_jtag_tap_scan_bank: randomized scans checked against a stream model of each scan chain
module tb_jtag_tap_scan_bank;
  import jtag_pkg::*;
  localparam int IRW = 3, NDR = 2, DW = 8;
`ifdef JTAG_IDCODE_EN
  localparam logic [IRW-1:0] RST_I = 3'b110;
`else
  localparam logic [IRW-1:0] RST_I = 3'b111;
`endif
  logic clk = 1'b0, reset = 1'b1, tms = 1'b1, tdi = 1'b0;
  logic tdo, tdo_en;
  logic [IRW-1:0] ir_status = '0, instruction;
  logic [NDR*DW-1:0] dr_capture = '0, dr_q;
  logic [NDR-1:0] dr_update;
  logic [3:0] tap_state;
  logic [IRW-1:0] m_instr;
  logic [NDR*DW-1:0] m_dq;
  int vecs = 0, errs = 0;
  jtag_tap_scan_bank #(.IR_WIDTH(IRW), .NUM_DR(NDR), .DR_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .ir_status(ir_status), .instruction(instruction), .dr_capture(dr_capture),
    .dr_q(dr_q), .dr_update(dr_update), .tap_state(tap_state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input bit m, input bit d, output bit o);
    tms = m;
    tdi = d;
    #1 o = tdo;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_state", 64'(tap_state), 64'hF);
    chk("rst_instr", 64'(instruction), 64'(RST_I));
    chk("rst_dr_q", 64'(dr_q), 64'hFFFF);
    chk("rst_tdo", 64'(tdo), 64'd0);
    chk("rst_tdo_en", 64'(tdo_en), 64'd0);
    chk("rst_dr_update", 64'(dr_update), 64'd0);
    reset = 1'b1;
    m_instr = RST_I;
    m_dq = '1;
  endtask
  task automatic tlr_rti();
    bit o;
    repeat (5) tick(1'b1, 1'($urandom), o);
    chk("tlr_state", 64'(tap_state), 64'hF);
    chk("tlr_instr", 64'(instruction), 64'(RST_I));
    chk("tlr_dr_q", 64'(dr_q), 64'(m_dq));
    m_instr = RST_I;
    tick(1'b0, 1'b0, o);
  endtask
  task automatic pause_n(input int n);
    bit o;
    tick(1'b0, 1'b0, o);
    repeat (n) begin
      tick(1'b0, 1'($urandom), o);
      chk("pause_tdo", 64'(o), 64'd0);
    end
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
  endtask
  task automatic ir_scan(input logic [IRW-1:0] v, input logic [IRW-1:0] st, input bit pz);
    bit o;
    int p;
    ir_status = st;
    tick(1'b1, 1'b0, o);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    chk("ir_state", 64'(tap_state), 64'hA);
    chk("ir_tdo_en", 64'(tdo_en), 64'd1);
    p = pz ? $urandom_range(0, IRW - 2) : -1;
    for (int k = 0; k < IRW; k++) begin
      tick(k == IRW - 1 || k == p, v[IRW-1-k], o);
      chk("ir_tdo", 64'(o), 64'(st[IRW-1-k]));
      if (k == p) pause_n(4);
    end
    tick(1'b1, 1'b0, o);
    chk("ir_hold_until_update", 64'(instruction), 64'(m_instr));
    tick(1'b0, 1'b0, o);
    m_instr = v;
    chk("ir_instr", 64'(instruction), 64'(m_instr));
  endtask
  task automatic dr_scan(input int n, input logic [63:0] din, input bit pz);
    bit s[$];
    int len, p;
    bit o;
    logic [31:0] cap;
    logic [DW-1:0] fin;
    len = 1;
    cap = 32'd0;
    if (int'(m_instr) < NDR) begin
      len = DW;
      cap = 32'(dr_capture[int'(m_instr)*DW +: DW]);
    end
`ifdef JTAG_IDCODE_EN
    else if (m_instr == 3'd6) begin
      len = 32;
      cap = IDCODE_DEFAULT;
    end
`endif
    for (int k = len - 1; k >= 0; k--) s.push_back(cap[k]);
    for (int k = n - 1; k >= 0; k--) s.push_back(din[k]);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    chk("dr_state", 64'(tap_state), 64'h2);
    p = (pz && n > 1) ? $urandom_range(0, n - 2) : -1;
    for (int k = 0; k < n; k++) begin
      tick(k == n - 1 || k == p, din[n-1-k], o);
      chk("dr_tdo", 64'(o), 64'(s[k]));
      if (k == p) pause_n(1 + $urandom_range(0, 3));
    end
    tick(1'b1, 1'b0, o);
    chk("upd_state", 64'(tap_state), 64'h5);
    chk("dr_update", 64'(dr_update), int'(m_instr) < NDR ? 64'd1 << m_instr : 64'd0);
    tick(1'b0, 1'b0, o);
    chk("dr_update_clear", 64'(dr_update), 64'd0);
    if (int'(m_instr) < NDR) begin
      for (int j = 0; j < DW; j++) fin[DW-1-j] = s[n+j];
      m_dq[int'(m_instr)*DW +: DW] = fin;
    end
    chk("dr_q", 64'(dr_q), 64'(m_dq));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit o;
    #2;
    do_reset();
    @(posedge clk);
    #1;
`ifdef JTAG_IDCODE_EN
    tick(1'b0, 1'b0, o);
    chk("idcode_instr", 64'(instruction), 64'h6);
    dr_scan(32, {$urandom, $urandom}, 1'b0);
    tlr_rti();
`else
    tick(1'b0, 1'b0, o);
`endif
    tlr_rti();
    ir_scan(3'b001, 3'b101, 1'b1);
    dr_capture = {8'hA5, 8'(($urandom))};
    dr_scan(8, 64'h3C, 1'b0);
    chk("dr1_3c", 64'(dr_q[15:8]), 64'h3C);
    chk("dr0_hold", 64'(dr_q[7:0]), 64'hFF);
    ir_scan(3'b111, 3'($urandom), 1'b0);
    dr_scan(4, 64'b1011, 1'b0);
    tlr_rti();
    repeat (40) begin
      dr_capture = 16'($urandom);
      case ($urandom_range(0, 5))
        0, 1: ir_scan(3'($urandom), 3'($urandom), 1'($urandom));
        2, 3: dr_scan($urandom_range(1, 40), {$urandom, $urandom}, 1'($urandom));
        4: begin
          repeat ($urandom_range(1, 12)) tick(1'($urandom), 1'($urandom), o);
          repeat (5) tick(1'b1, 1'($urandom), o);
          chk("walk_tlr", 64'(tap_state), 64'hF);
          chk("walk_instr", 64'(instruction), 64'(RST_I));
          do_reset();
          tick(1'b0, 1'b0, o);
        end
        default: begin
          tick(1'b1, 1'b0, o);
          tick(1'b0, 1'b0, o);
          tick(1'b0, 1'b0, o);
          repeat ($urandom_range(1, 5)) tick(1'b0, 1'($urandom), o);
          do_reset();
          tick(1'b0, 1'b0, o);
        end
      endcase
    end
    tlr_rti();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
